// File: rtl/reg_file_flags_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_flags_pkg
// Shared definitions for the register file / flag block and its decoder:
// default operand and address widths, the register count, the run/halt state
// encoding, and the ALU opcode enumeration with a helper that derives the
// register-file control strobes from an opcode.
// -----------------------------------------------------------------------------
package reg_file_flags_pkg;

    localparam int W_DEF        = 8;
    localparam int A_DEF        = 3;
    localparam int NUM_REGS_DEF = 1 << A_DEF;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } run_state_e;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_MOV  = 3'd5,
        OP_RST  = 3'd6,
        OP_HALT = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic write_en;
        logic flag_wr_en;
        logic flag_clr;
        logic halt;
    } ctrl_t;

    // Arithmetic ops produce a carry/borrow, so they update the flag as well
    // as the destination register; logical ops leave the flag alone.
    function automatic ctrl_t decode_op(alu_op_e op);
        ctrl_t c;
        c = '0;
        unique case (op)
            OP_ADD, OP_SUB: begin
                c.write_en   = 1'b1;
                c.flag_wr_en = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR, OP_MOV: c.write_en = 1'b1;
            OP_RST:  c.flag_clr = 1'b1;
            OP_HALT: c.halt     = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/reg_file_flags_if.sv
// -----------------------------------------------------------------------------
// reg_file_flags_if
// Bus between the decoder/ALU (master) and the register file (slave).
//   master drives : RaddrA, RaddrB, Waddr, WriteEn, DataIn,
//                   FlagWrEn, FlagIn, FlagClr, Halt
//   slave drives  : DataOutA, DataOutB, FlagOut, Halted
// -----------------------------------------------------------------------------
interface reg_file_flags_if #(
    parameter int W = 8,
    parameter int A = 3
);
    logic [A-1:0] RaddrA;
    logic [A-1:0] RaddrB;
    logic [A-1:0] Waddr;
    logic         WriteEn;
    logic [W-1:0] DataIn;
    logic         FlagWrEn;
    logic         FlagIn;
    logic         FlagClr;
    logic         Halt;
    logic [W-1:0] DataOutA;
    logic [W-1:0] DataOutB;
    logic         FlagOut;
    logic         Halted;

    modport master (
        output RaddrA, RaddrB, Waddr, WriteEn, DataIn,
               FlagWrEn, FlagIn, FlagClr, Halt,
        input  DataOutA, DataOutB, FlagOut, Halted
    );

    modport slave (
        input  RaddrA, RaddrB, Waddr, WriteEn, DataIn,
               FlagWrEn, FlagIn, FlagClr, Halt,
        output DataOutA, DataOutB, FlagOut, Halted
    );
endinterface

// File: rtl/reg_file_flags_flag_reg.sv
// -----------------------------------------------------------------------------
// reg_file_flags_flag_reg
// Carry/borrow flag plus the sticky RUN/HALTED state machine.
//   clk, rst    : clock, asynchronous active-high reset
//   flag_wr_en  : load flag_in at the edge
//   flag_in     : next flag value (ALU overflow out)
//   flag_clr    : clear the flag; wins over flag_wr_en
//   halt        : enter HALTED at the edge (left only through rst)
//   flag_out    : committed flag
//   halted      : high while in HALTED
// -----------------------------------------------------------------------------
module reg_file_flags_flag_reg
    import reg_file_flags_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic flag_wr_en,
    input  logic flag_in,
    input  logic flag_clr,
    input  logic halt,
    output logic flag_out,
    output logic halted
);

    run_state_e state_q, state_d;
    logic       flag_q, flag_d;

    // Updates are gated on the *current* state, so an update presented in the
    // same cycle as halt still lands; everything after that edge is frozen.
    always_comb begin
        state_d = state_q;
        flag_d  = flag_q;
        if (state_q == ST_RUN) begin
            if (flag_clr) begin
                flag_d = 1'b0;
            end else if (flag_wr_en) begin
                flag_d = flag_in;
            end
            if (halt) begin
                state_d = ST_HALTED;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
        end
    end

    assign flag_out = flag_q;
    assign halted   = (state_q == ST_HALTED);

endmodule

// File: rtl/reg_file_flags.sv
// -----------------------------------------------------------------------------
// reg_file_flags
// Architectural register file (2**A x W) with two combinational read ports,
// one write port, and the carry/borrow flag + sticky halt status.
//   Clk, Reset : clock, asynchronous active-high reset (clears everything)
//   bus        : slave side of reg_file_flags_if (reads, write, flag, halt)
// BYPASS=1 forwards a same-cycle write to a matching read port while running.
// -----------------------------------------------------------------------------
module reg_file_flags
    import reg_file_flags_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int A      = A_DEF,
    parameter int BYPASS = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    reg_file_flags_if.slave      bus
);

    localparam int NREGS = 1 << A;

    logic [W-1:0] regs_q [NREGS];
    logic [W-1:0] regs_d [NREGS];
    logic         halted;
    logic         flag;
    logic         fwd_en;

    reg_file_flags_flag_reg u_flag_reg (
        .clk        (Clk),
        .rst        (Reset),
        .flag_wr_en (bus.FlagWrEn),
        .flag_in    (bus.FlagIn),
        .flag_clr   (bus.FlagClr),
        .halt       (bus.Halt),
        .flag_out   (flag),
        .halted     (halted)
    );

    always_comb begin
        regs_d = regs_q;
        if (bus.WriteEn && !halted) begin
            regs_d[bus.Waddr] = bus.DataIn;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Forwarding is suppressed under Reset so the read ports show the cleared
    // array, and under halt so only committed values are visible.
    assign fwd_en = (BYPASS != 0) && bus.WriteEn && !halted && !Reset;

    assign bus.DataOutA = (fwd_en && (bus.Waddr == bus.RaddrA)) ? bus.DataIn
                                                                : regs_q[bus.RaddrA];
    assign bus.DataOutB = (fwd_en && (bus.Waddr == bus.RaddrB)) ? bus.DataIn
                                                                : regs_q[bus.RaddrB];

    // The flag is never forwarded: the ALU carry-in must come from a flop.
    assign bus.FlagOut = flag;
    assign bus.Halted  = halted;

endmodule
